// File: rtl/div3_pkg.sv
// div3_pkg: shared types and constants for the serial divide-by-3 unit
package div3_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DIV3_REM_W = 2;
  localparam logic [DIV3_REM_W:0] DIV3_DIVISOR = 3'd3;
endpackage

// File: rtl/div3_serial_if.sv
// div3_serial_if: dividend input and quotient/remainder output handshake bundle
interface div3_serial_if
  import div3_pkg::*;
#(
  parameter int W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_q;
  logic [DIV3_REM_W-1:0] out_r;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_q, out_r);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_q, out_r);
endinterface

// File: rtl/div3_step.sv
// div3_step: one MSB-first long-division step by 3
module div3_step
  import div3_pkg::*;
(
  input  logic [DIV3_REM_W-1:0] rem,
  input  logic                  din,
  output logic                  qbit,
  output logic [DIV3_REM_W-1:0] rem_next
);
  logic [DIV3_REM_W:0] t;
  // subtract the divisor whenever the partial remainder reaches it; result stays 0..2
  always_comb begin
    t = {rem, din};
    qbit = t >= DIV3_DIVISOR;
    rem_next = qbit ? DIV3_REM_W'(t - DIV3_DIVISOR) : DIV3_REM_W'(t);
  end
endmodule

// File: rtl/div3_serial.sv
// div3_serial: bit-serial divide-by-3, one quotient bit per clock
module div3_serial
  import div3_pkg::*;
#(
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst_n,
  div3_serial_if.slave bus
);
  localparam int CW = $clog2(W);
  state_e                state_q, state_d;
  logic [W-1:0]          dvd_q, dvd_d, quo_q, quo_d, oq_q, oq_d;
  logic [DIV3_REM_W-1:0] rem_q, rem_d, or_q, or_d, rem_nx;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  qbit;

  div3_step u_step (.rem(rem_q), .din(dvd_q[W-1]), .qbit(qbit), .rem_next(rem_nx));

  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_q     = oq_q;
  assign bus.out_r     = or_q;

  // accept in IDLE, one division step per RUN cycle, publish result registers on entering DONE
  always_comb begin
    state_d = state_q;
    dvd_d = dvd_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    oq_d = oq_q;
    or_d = or_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = RUN;
        dvd_d = bus.in_data;
        quo_d = '0;
        rem_d = '0;
        cnt_d = CW'(W - 1);
      end
      RUN: begin
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[W-2:0], qbit};
        rem_d = rem_nx;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        state_d = cnt_q == '0 ? DONE : RUN;
        oq_d = cnt_q == '0 ? {quo_q[W-2:0], qbit} : oq_q;
        or_d = cnt_q == '0 ? rem_nx : or_q;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      oq_q <= '0;
      or_q <= '0;
    end else begin
      state_q <= state_d;
      dvd_q <= dvd_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      oq_q <= oq_d;
      or_q <= or_d;
    end
  end
endmodule

// File: tb/tb_div3_serial.sv
// tb_div3_serial: directed table-driven checks of div3_serial and div3_step
module tb_div3_serial;
  import div3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div3_serial_if #(.W(8)) b8 ();
  div3_serial_if #(.W(4)) b4 ();
  div3_serial #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  div3_serial #(.W(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  logic [1:0] s_rem, s_rn;
  logic       s_bit, s_q;
  div3_step u_step (.rem(s_rem), .din(s_bit), .qbit(s_q), .rem_next(s_rn));

  typedef struct { logic [7:0] d; logic [7:0] q; logic [1:0] r; } vec_t;
  typedef struct { logic [1:0] rem; logic b; logic q; logic [1:0] rn; } step_t;

  vec_t  vecs [8];
  vec_t  b2b  [4];
  step_t steps [6];
  int n_chk = 0;
  int n_fail = 0;
  int cyc, stall, idx, got;
  int acc [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait8();
    cyc = 0;
    while (!b8.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input logic [7:0] d, input logic [7:0] q, input logic [1:0] r);
    @(negedge clk);
    check("op_in_ready", 32'(b8.in_ready), 1);
    b8.in_valid = 1'b1;
    b8.in_data = d;
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.in_data = ~d;
    wait8();
    check("op_latency", cyc, 8);
    check("op_q", 32'(b8.out_q), 32'(q));
    check("op_r", 32'(b8.out_r), 32'(r));
    @(negedge clk);
    check("op_valid_drop", 32'(b8.out_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{'{8'd100, 8'd33, 2'd1}, '{8'd255, 8'd85, 2'd0}, '{8'd8, 8'd2, 2'd2}, '{8'd0, 8'd0, 2'd0},
             '{8'd200, 8'd66, 2'd2}, '{8'd77, 8'd25, 2'd2}, '{8'd3, 8'd1, 2'd0}, '{8'd1, 8'd0, 2'd1}};
    b2b = '{'{8'd17, 8'd5, 2'd2}, '{8'd250, 8'd83, 2'd1}, '{8'd5, 8'd1, 2'd2}, '{8'd129, 8'd43, 2'd0}};
    steps = '{'{2'd0, 1'b0, 1'b0, 2'd0}, '{2'd0, 1'b1, 1'b0, 2'd1}, '{2'd1, 1'b0, 1'b0, 2'd2},
              '{2'd1, 1'b1, 1'b1, 2'd0}, '{2'd2, 1'b0, 1'b1, 2'd1}, '{2'd2, 1'b1, 1'b1, 2'd2}};
    b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_rem = steps[i].rem;
      s_bit = steps[i].b;
      #1;
      check("step_q", 32'(s_q), 32'(steps[i].q));
      check("step_rem", 32'(s_rn), 32'(steps[i].rn));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(b8.in_ready), 1);
    check("rst_out_valid", 32'(b8.out_valid), 0);
    check("rst_out_q", 32'(b8.out_q), 0);
    check("rst_out_r", 32'(b8.out_r), 0);
    for (int i = 0; i < 8; i++) do_op(vecs[i].d, vecs[i].q, vecs[i].r);
    // backpressure on result 200 while a new operand waits
    b8.out_ready = 1'b0;
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_data = 8'd200;
    @(negedge clk);
    b8.in_data = 8'd10;
    wait8();
    check("bp_latency", cyc, 8);
    check("bp_q", 32'(b8.out_q), 66);
    check("bp_r", 32'(b8.out_r), 2);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(b8.out_valid), 1);
      check("bp_hold_q", 32'(b8.out_q), 66);
      check("bp_hold_r", 32'(b8.out_r), 2);
      check("bp_hold_in_ready", 32'(b8.in_ready), 0);
    end
    b8.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(b8.out_valid), 0);
    check("bp_release_in_ready", 32'(b8.in_ready), 1);
    @(negedge clk);
    check("bp_accept_in_ready", 32'(b8.in_ready), 0);
    b8.in_valid = 1'b0;
    wait8();
    check("bp_next_latency", cyc, 8);
    check("bp_next_q", 32'(b8.out_q), 3);
    check("bp_next_r", 32'(b8.out_r), 1);
    @(negedge clk);
    // back-to-back with in_valid held high
    idx = 0;
    got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      @(negedge clk);
      if (b8.out_valid) begin
        check("b2b_q", 32'(b8.out_q), 32'(b2b[got].q));
        check("b2b_r", 32'(b8.out_r), 32'(b2b[got].r));
        got++;
      end
      if (b8.in_ready && idx < 4) begin
        b8.in_valid = 1'b1;
        b8.in_data = b2b[idx].d;
        acc[idx] = c;
        idx++;
      end
    end
    b8.in_valid = 1'b0;
    check("b2b_results", got, 4);
    for (int i = 0; i < 3; i++) check("b2b_gap", acc[i+1] - acc[i], 10);
    // reset on the 4th RUN cycle of 77
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_data = 8'd77;
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_running", 32'(b8.in_ready), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(b8.in_ready), 1);
    check("mid_rst_valid", 32'(b8.out_valid), 0);
    check("mid_rst_q", 32'(b8.out_q), 0);
    check("mid_rst_r", 32'(b8.out_r), 0);
    do_op(8'd77, 8'd25, 2'd2);
    // exhaustive W=4 with random result stalls
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b4.in_valid = 1'b1;
      b4.in_data = 4'(i);
      b4.out_ready = 1'b0;
      @(negedge clk);
      b4.in_valid = 1'b0;
      cyc = 0;
      while (!b4.out_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("w4_latency", cyc, 4);
      check("w4_q", 32'(b4.out_q), i / 3);
      check("w4_r", 32'(b4.out_r), i % 3);
      check("w4_r_not3", 32'(b4.out_r == 2'd3), 0);
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin
        @(negedge clk);
        check("w4_stall_valid", 32'(b4.out_valid), 1);
        check("w4_stall_q", 32'(b4.out_q), i / 3);
      end
      b4.out_ready = 1'b1;
      @(negedge clk);
      check("w4_done", 32'(b4.out_valid), 0);
      b4.out_ready = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div3_serial.md
# div3_serial

Bit-serial divide-by-3 unit for W-bit unsigned operands. It takes one dividend per valid/ready handshake and performs MSB-first long division, one bit per clock. It returns the quotient and remainder on a valid/ready output port. It is the multi-cycle companion to the lab's combinational 4-bit divide-by-3 stage, extending it to wide operands at one bit per cycle of area cost.

## Interface
- W, default 8: dividend and quotient width, in bits (W ≥ 2).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  producer holds in_data valid.
- in_ready  out  1  unit can accept a dividend.
- in_data  in  W  unsigned dividend.
- out_valid  out  1  out_q and out_r are valid.
- out_ready  in  1  consumer accepts the result.
- out_q  out  W  quotient, floor(in_data/3).
- out_r  out  2  remainder, in_data mod 3 (always 0..2).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: load shift register with in_data, clear rem to 0, clear the quotient register, set cnt=W-1, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, form t={rem, dividend MSB} (3 bits, value 0..5).
  - qbit = (t ≥ 3); rem' = t − 3·qbit (2 bits, never 3).
  - Shift the dividend left by 1; shift qbit into the quotient LSB.
  - When cnt==0, go to DONE; otherwise decrement cnt.
- DONE:
  - out_valid=1; out_q and out_r are driven from the registers.
  - On out_ready=1: go to IDLE.
  - Otherwise hold all outputs stable.
- in_ready is asserted only in IDLE. It is a combinational decode of the state; there is no path from in_valid to in_ready.
- Outputs keep their last values in IDLE and RUN. Consumers may use them only while out_valid=1.
- cnt width is clog2(W). The unit never wraps; exactly W iterations are performed per operand.
- in_data is sampled only on the accept edge. Changes to in_data during RUN or DONE have no effect.
- in_valid during RUN or DONE is ignored. The producer keeps holding it until in_ready is seen.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, out_valid=0, out_q=0, out_r=0, rem=0, cnt=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation (RUN or DONE): the operation is aborted on that edge, with no result emitted and all registers as above.
- rst_n has priority over all other inputs on the same edge.
- Latency: if the accept edge is E0, out_valid rises after edge E0+W (W cycles in RUN).
- Output handshake at edge Ed (out_valid & out_ready) → IDLE. The next dividend can be accepted at edge Ed+1.
- Minimum initiation interval is W+2 cycles. in_valid may be held continuously.
- out_ready held low: DONE persists indefinitely with out_valid=1 and the result unchanged.

## Structure
- Shared package div3_pkg:
  - state enum: IDLE, RUN, DONE.
  - DIV3_REM_W=2.
  - Divisor constant 3.
- Sub-module div3_step (combinational):
  - Inputs: rem[1:0], bit.
  - Outputs: qbit, rem_next[1:0].
  - One instance in RUN, so the step can be unit-tested exhaustively on its own.
- The top module contains the FSM, shift registers, counter and handshake.

## Test plan
- After reset (W=8): in_ready=1, out_valid=0, out_q=0, out_r=0. Then:
  - in_data=100 → after 8 cycles out_valid=1, out_q=33, out_r=1.
  - in_data=255 → out_q=85, out_r=0.
  - in_data=8 → out_q=2, out_r=2.
  - in_data=0 → out_q=0, out_r=0.
- Backpressure: result for 200 (out_q=66, out_r=2) with out_ready=0 for 5 cycles.
  - out_valid stays 1 and outputs stay stable.
  - in_ready stays 0.
  - A new in_valid is not accepted until 1 cycle after out_ready=1.
- Back-to-back: in_valid held high with a fresh operand after each accept, out_ready=1.
  - Accepts are exactly 10 cycles apart.
  - Each result matches its operand.
- Reset mid-operation: rst_n=0 on the 4th RUN cycle of in_data=77.
  - Next cycle: IDLE, out_valid=0, out_q=0, out_r=0.
  - A subsequent 77 gives 25 r 2.
- Exhaustive at W=4: all in_data 0..15 with random out_ready stalls.
  - out_q and out_r match floor(i/3) and i mod 3 (e.g. 15→5 r0, 14→4 r2).
  - out_r is never 3.
